// File: rtl/gpi_debounce.sv
// General-purpose input port: 2-flop sync, per-pin debounce, sticky edge pending, device-bus registers.
// Optional GPI_IRQ_EN adds the IRQ_EN register and the level interrupt; otherwise irq_o is tied low.
`timescale 1ns/1ps
module gpi_debounce #(
    parameter int unsigned GpiWidth       = 8,
    parameter int unsigned DebounceCycles = 1000
) (
    input  logic                clk_sys_i,
    input  logic                rst_sys_ni,
    input  logic [GpiWidth-1:0] gp_i,
    input  logic                device_req_i,
    input  logic [31:0]         device_addr_i,
    input  logic                device_we_i,
    input  logic [3:0]          device_be_i,
    input  logic [31:0]         device_wdata_i,
    output logic                device_rvalid_o,
    output logic [31:0]         device_rdata_o,
    output logic                irq_o
);

    localparam int unsigned    CntW   = $clog2(DebounceCycles + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(DebounceCycles - 1);

    typedef enum logic [1:0] {
        RegValue = 2'd0,
        RegRise  = 2'd1,
        RegFall  = 2'd2,
        RegIrqEn = 2'd3
    } reg_addr_e;

    logic [GpiWidth-1:0] sync1_q, sync2_q;
    logic [GpiWidth-1:0] deb_q, deb_d;
    logic [CntW-1:0]     cnt_q [GpiWidth];
    logic [CntW-1:0]     cnt_d [GpiWidth];
    logic [GpiWidth-1:0] rise_q, rise_d, fall_q, fall_d;
    logic [GpiWidth-1:0] rise_set, fall_set;
    logic [GpiWidth-1:0] irq_en_val;
    logic                rvalid_q;
    logic [31:0]         rdata_q, rdata_d;

    reg_addr_e           addr_sel;
    logic                wr_en;
    logic [31:0]         be_mask;
    logic [31:0]         wr_bits;
    logic [GpiWidth-1:0] wr_bits_g;
    logic [31:0]         rd_val;
    logic                unused_bits;

    always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
        if (!rst_sys_ni) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= gp_i;
            sync2_q <= sync1_q;
        end
    end

    // A pin is accepted only after DebounceCycles consecutive cycles away from deb.
    always_comb begin
        deb_d = deb_q;
        for (int unsigned i = 0; i < GpiWidth; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != deb_q[i]) begin
                if (cnt_q[i] == CntMax) begin
                    deb_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CntW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
        if (!rst_sys_ni) begin
            deb_q <= '0;
            for (int unsigned i = 0; i < GpiWidth; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            deb_q <= deb_d;
            for (int unsigned i = 0; i < GpiWidth; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign rise_set = deb_d & ~deb_q;
    assign fall_set = ~deb_d & deb_q;

    assign addr_sel = reg_addr_e'(device_addr_i[3:2]);
    assign wr_en    = device_req_i & device_we_i;

    always_comb begin
        for (int unsigned b = 0; b < 4; b++) begin
            be_mask[8*b +: 8] = {8{device_be_i[b]}};
        end
    end

    assign wr_bits   = device_wdata_i & be_mask;
    assign wr_bits_g = wr_bits[GpiWidth-1:0];

    // Clear is applied before the set so a same-cycle edge keeps the bit pending.
    always_comb begin
        rise_d = rise_q;
        fall_d = fall_q;
        if (wr_en && addr_sel == RegRise) begin
            rise_d = rise_q & ~wr_bits_g;
        end
        if (wr_en && addr_sel == RegFall) begin
            fall_d = fall_q & ~wr_bits_g;
        end
        rise_d = rise_d | rise_set;
        fall_d = fall_d | fall_set;
    end

    always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
        if (!rst_sys_ni) begin
            rise_q <= '0;
            fall_q <= '0;
        end else begin
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

`ifdef GPI_IRQ_EN
    logic [GpiWidth-1:0] irq_en_q, irq_en_d;
    logic                irq_q, irq_d;
    logic [GpiWidth-1:0] be_mask_g;

    assign be_mask_g = be_mask[GpiWidth-1:0];

    always_comb begin
        irq_en_d = irq_en_q;
        if (wr_en && addr_sel == RegIrqEn) begin
            irq_en_d = (irq_en_q & ~be_mask_g) | wr_bits_g;
        end
    end

    assign irq_d = |((rise_q | fall_q) & irq_en_q);

    always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
        if (!rst_sys_ni) begin
            irq_en_q <= '0;
            irq_q    <= 1'b0;
        end else begin
            irq_en_q <= irq_en_d;
            irq_q    <= irq_d;
        end
    end

    assign irq_en_val = irq_en_q;
    assign irq_o      = irq_q;
`else
    assign irq_en_val = '0;
    assign irq_o      = 1'b0;
`endif

    always_comb begin
        rd_val = '0;
        unique case (addr_sel)
            RegValue: rd_val[GpiWidth-1:0] = deb_q;
            RegRise:  rd_val[GpiWidth-1:0] = rise_q;
            RegFall:  rd_val[GpiWidth-1:0] = fall_q;
            RegIrqEn: rd_val[GpiWidth-1:0] = irq_en_val;
            default:  rd_val = '0;
        endcase
    end

    always_comb begin
        rdata_d = '0;
        if (device_req_i && !device_we_i) begin
            rdata_d = rd_val;
        end
    end

    always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
        if (!rst_sys_ni) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            rvalid_q <= device_req_i;
            rdata_q  <= rdata_d;
        end
    end

    assign device_rvalid_o = rvalid_q;
    assign device_rdata_o  = rdata_q;

    assign unused_bits = ^{device_addr_i[31:4], device_addr_i[1:0], wr_bits};

endmodule

// File: tb/tb_gpi_debounce.sv
// Bench for gpi_debounce (GpiWidth=8, DebounceCycles=4): directed steps plus random traffic against a window-based reference model.
`timescale 1ns/1ps
module tb_gpi_debounce;
    localparam int unsigned W = 8;
    localparam int unsigned D = 4;

`ifdef GPI_IRQ_EN
    localparam bit HasIrq = 1'b1;
`else
    localparam bit HasIrq = 1'b0;
`endif

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] gp    = '0;
    logic         req   = 1'b0;
    logic         we    = 1'b0;
    logic [31:0]  addr  = '0;
    logic [3:0]   be    = '0;
    logic [31:0]  wdata = '0;
    logic         rvalid, irq;
    logic [31:0]  rdata;

    int checks = 0;
    int errors = 0;

    gpi_debounce #(.GpiWidth(W), .DebounceCycles(D)) dut (
        .clk_sys_i      (clk),
        .rst_sys_ni     (rst_n),
        .gp_i           (gp),
        .device_req_i   (req),
        .device_addr_i  (addr),
        .device_we_i    (we),
        .device_be_i    (be),
        .device_wdata_i (wdata),
        .device_rvalid_o(rvalid),
        .device_rdata_o (rdata),
        .irq_o          (irq)
    );

    always #5 clk = ~clk;

    // Reference model: a pin value is accepted once the last D synchronised samples all disagree with deb.
    logic [W-1:0] m_s1, m_s2, m_deb, m_rise, m_fall, m_en;
    logic [W-1:0] m_win[$];
    logic         m_rvalid, m_irq;
    logic [31:0]  m_rdata;

    task automatic model_reset();
        m_s1 = '0; m_s2 = '0; m_deb = '0; m_rise = '0; m_fall = '0; m_en = '0;
        m_rvalid = 1'b0; m_irq = 1'b0; m_rdata = '0;
        m_win = {};
        for (int k = 0; k < D; k++) m_win.push_back('0);
    endtask

    task automatic model_step();
        logic [W-1:0] deb_new, set_r, set_f, wm, bm;
        logic [31:0]  mask32, wm32, rd;
        logic         all_diff;
        m_win.push_back(m_s2);
        void'(m_win.pop_front());
        deb_new = m_deb;
        for (int b = 0; b < W; b++) begin
            all_diff = 1'b1;
            foreach (m_win[k]) if (m_win[k][b] == m_deb[b]) all_diff = 1'b0;
            if (all_diff) deb_new[b] = ~m_deb[b];
        end
        set_r  = deb_new & ~m_deb;
        set_f  = ~deb_new & m_deb;
        mask32 = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
        wm32   = wdata & mask32;
        wm     = wm32[W-1:0];
        bm     = mask32[W-1:0];
        case (addr[3:2])
            2'd0:    rd = 32'(m_deb);
            2'd1:    rd = 32'(m_rise);
            2'd2:    rd = 32'(m_fall);
            default: rd = 32'(m_en);
        endcase
        m_rdata  = (req && !we) ? rd : 32'h0;
        m_rvalid = req;
        m_irq    = HasIrq && (|((m_rise | m_fall) & m_en));
        m_rise   = (m_rise & ~((req && we && addr[3:2] == 2'd1) ? wm : '0)) | set_r;
        m_fall   = (m_fall & ~((req && we && addr[3:2] == 2'd2) ? wm : '0)) | set_f;
        if (HasIrq && req && we && addr[3:2] == 2'd3) m_en = (m_en & ~bm) | wm;
        m_deb = deb_new;
        m_s2  = m_s1;
        m_s1  = gp;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        if (rst_n) model_step(); else model_reset();
        @(posedge clk);
        @(negedge clk);
        chk("rvalid", 32'(rvalid), 32'(m_rvalid));
        chk("rdata", rdata, m_rdata);
        chk("irq", 32'(irq), 32'(m_irq));
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cycle();
    endtask

    task automatic bus_rd(input logic [31:0] a, output logic [31:0] d);
        req = 1'b1; we = 1'b0; addr = a; be = 4'hF; wdata = '0;
        cycle();
        d = rdata;
        req = 1'b0;
    endtask

    task automatic bus_wr(input logic [31:0] a, input logic [3:0] b, input logic [31:0] dat);
        req = 1'b1; we = 1'b1; addr = a; be = b; wdata = dat;
        cycle();
        req = 1'b0; we = 1'b0; be = '0; wdata = '0;
    endtask

    initial begin
        logic [31:0] d, d0, d1, d2;
        model_reset();
        idle(3);
        rst_n = 1'b1;

        // Reset state
        chk("reset_irq", 32'(irq), 32'h0);
        bus_rd(32'h0, d); chk("reset_value", d, 32'h0);
        bus_rd(32'h4, d); chk("reset_rise", d, 32'h0);
        bus_rd(32'h8, d); chk("reset_fall", d, 32'h0);
        bus_rd(32'hC, d); chk("reset_en", d, 32'h0);

        // Debounce latency: a read at edge n reports deb as of edge n-1; acceptance at edge 2+D
        gp = 8'h01;
        for (int n = 1; n <= 8; n++) begin
            bus_rd(32'h0, d);
            chk("latency_value", d, (n >= 7) ? 32'h1 : 32'h0);
        end
        bus_rd(32'h4, d); chk("latency_rise", d, 32'h1);
        bus_wr(32'h4, 4'hF, 32'h1);

        // Glitch rejection: 3 cycles high is one short of acceptance
        gp = 8'h09;
        idle(3);
        gp = 8'h01;
        idle(10);
        bus_rd(32'h0, d); chk("glitch_value", d, 32'h1);
        bus_rd(32'h4, d); chk("glitch_rise", d, 32'h0);
        bus_rd(32'h8, d); chk("glitch_fall", d, 32'h0);

        // W1C
        gp = 8'h00; idle(8);
        bus_rd(32'h8, d); chk("fall_bit0", d, 32'h1);
        bus_wr(32'h8, 4'hF, 32'hFF);
        gp = 8'h03; idle(8);
        bus_rd(32'h4, d); chk("rise_03", d, 32'h3);
        bus_wr(32'h4, 4'hF, 32'h1);
        bus_rd(32'h4, d); chk("w1c_bit0", d, 32'h2);

        // Set wins over a same-cycle W1C
        gp = 8'h01; idle(8);
        bus_wr(32'h8, 4'hF, 32'hFF);
        bus_wr(32'h4, 4'hF, 32'hFF);
        bus_rd(32'h4, d); chk("rise_cleared", d, 32'h0);
        gp = 8'h03;
        idle(5);
        bus_wr(32'h4, 4'h1, 32'h2);
        bus_rd(32'h4, d); chk("set_wins", d, 32'h2);

        // Interrupt
        gp = 8'h07; idle(8);
        bus_wr(32'h4, 4'hF, 32'hFF);
        bus_wr(32'h8, 4'hF, 32'hFF);
        bus_wr(32'hC, 4'hF, 32'h4);
        idle(2);
        chk("irq_idle", 32'(irq), 32'h0);
        gp = 8'h03;
        idle(6);
        chk("irq_before", 32'(irq), 32'h0);
        idle(1);
        chk("irq_set", 32'(irq), 32'(HasIrq));
        bus_rd(32'h8, d); chk("irq_fall", d, 32'h4);
        bus_wr(32'h8, 4'hF, 32'h4);
        chk("irq_hold", 32'(irq), 32'(HasIrq));
        idle(1);
        chk("irq_clear", 32'(irq), 32'h0);

        // Back-to-back reads
        req = 1'b1; we = 1'b0; be = 4'hF;
        addr = 32'h0; cycle(); chk("b2b_rv0", 32'(rvalid), 32'h1); d0 = rdata;
        addr = 32'h4; cycle(); chk("b2b_rv1", 32'(rvalid), 32'h1); d1 = rdata;
        addr = 32'hC; cycle(); chk("b2b_rv2", 32'(rvalid), 32'h1); d2 = rdata;
        req = 1'b0;
        chk("b2b_d0", d0, 32'h3);
        chk("b2b_d1", d1, 32'h0);
        chk("b2b_d2", d2, HasIrq ? 32'h4 : 32'h0);
        idle(1);
        chk("b2b_end", 32'(rvalid), 32'h0);

        // Byte enables on IRQ_EN; VALUE is read-only
        bus_wr(32'hC, 4'b0010, 32'hFFFF_FFFF);
        bus_rd(32'hC, d); chk("be_byte1", d, HasIrq ? 32'h4 : 32'h0);
        bus_wr(32'hC, 4'b0001, 32'h0000_00F0);
        bus_rd(32'hC, d); chk("be_byte0", d, HasIrq ? 32'hF0 : 32'h0);
        bus_wr(32'h0, 4'hF, 32'hFF);
        bus_rd(32'h0, d); chk("value_ro", d, 32'h3);

        // Async reset mid-count with a pending interrupt
        bus_wr(32'hC, 4'hF, 32'hFF);
        gp = 8'h02; idle(8);
        chk("pre_rst_irq", 32'(irq), 32'(HasIrq));
        gp = 8'h12;
        idle(3);
        bus_rd(32'h0, d);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        chk("rst_rvalid", 32'(rvalid), 32'h0);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_irq", 32'(irq), 32'h0);
        idle(2);
        rst_n = 1'b1;
        for (int n = 1; n <= 8; n++) begin
            bus_rd(32'h0, d);
            chk("rst_latency", d, (n >= 7) ? 32'h12 : 32'h0);
        end
        bus_rd(32'h4, d); chk("rst_rise", d, 32'h12);
        bus_rd(32'h8, d); chk("rst_fall", d, 32'h0);
        bus_rd(32'hC, d); chk("rst_en", d, 32'h0);

        // Random traffic against the model
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 3) == 0) gp = gp ^ (8'(1) << $urandom_range(0, 7));
            req   = 1'($urandom_range(0, 1));
            we    = 1'($urandom_range(0, 1));
            addr  = $urandom;
            be    = 4'($urandom);
            wdata = $urandom;
            cycle();
        end
        req = 1'b0; we = 1'b0;
        idle(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/gpi_debounce.md
Name: gpi_debounce

Overview:
- General-purpose input peripheral for the Ibex super system; the input-side counterpart of the GPO/LED output port.
- Synchronises and debounces board push-buttons and DIP switches.
- Latches rising and falling edges into sticky pending registers and exposes them on the system device bus.
- Raises a level interrupt to the core when an enabled pending bit is set.

Parameters:
- GpiWidth, 8, number of input pins (1..32).
- DebounceCycles, 1000, clk_sys cycles a synchronised input must differ stably from the debounced value before it is accepted (>=2).

Ports:
- clk_sys_i  input  1  system clock.
- rst_sys_ni  input  1  reset; asynchronous, active-low.
- gp_i  input  GpiWidth  raw asynchronous board inputs.
- device_req_i  input  1  bus request, single-cycle.
- device_addr_i  input  32  byte address; only bits [3:2] decoded.
- device_we_i  input  1  write enable.
- device_be_i  input  4  byte enables.
- device_wdata_i  input  32  write data.
- device_rvalid_o  output  1  response valid.
- device_rdata_o  output  32  read data.
- irq_o  output  1  level interrupt.

Behaviour:
- Reset values:
  - synchroniser flops, debounced value, counters, RISE_PEND, FALL_PEND, IRQ_EN all 0.
  - device_rvalid_o 0, device_rdata_o 0, irq_o 0.
- Synchroniser:
  - 2-flop per bit; sync = second stage.
  - Input-to-sync latency is 2 cycles.
- Debounce, per bit, counter width $clog2(DebounceCycles+1):
  - sync == deb: counter clears to 0.
  - sync != deb and counter < DebounceCycles-1: counter increments.
  - sync != deb and counter == DebounceCycles-1: deb <= sync; counter clears to 0.
  - Any glitch back to deb restarts the count.
  - Accepted-change latency from a pin edge is exactly 2+DebounceCycles cycles.
- Edge detect: in the cycle deb goes 0->1 set RISE_PEND[i]; 1->0 set FALL_PEND[i].
- Register map, addr[3:2]:
  - 0 VALUE: RO, deb zero-extended.
  - 1 RISE_PEND: W1C.
  - 2 FALL_PEND: W1C.
  - 3 IRQ_EN: RW, bits [GpiWidth-1:0].
  - Bits above GpiWidth read 0 and ignore writes.
- Byte enables: a write affects only the bytes with be set. W1C applies only to bytes with be set.
- Simultaneous set and W1C on the same pending bit in the same cycle: set wins (bit ends 1).
- Writes to VALUE are ignored.
- Bus response:
  - device_rvalid_o asserts exactly 1 cycle after every device_req_i, reads and writes alike; back-to-back requests are supported every cycle.
  - device_rdata_o is valid for reads in the rvalid cycle. It reads the register value before any same-cycle update and is 0 for writes.
- Interrupt:
  - irq_o = |((RISE_PEND | FALL_PEND) & IRQ_EN), registered, 1-cycle latency.
  - irq_o stays high until the pending bits are cleared or IRQ_EN is cleared.
- Reset mid-operation: all state returns to its reset value immediately, with no spurious edge on release.
- Pins held high through reset produce a RISE_PEND after 2+DebounceCycles cycles; this is expected.

Optional Feature:
- GPI_IRQ_EN:
  - Defined: IRQ_EN register and irq_o logic are present as above.
  - Undefined: irq_o tied 0; IRQ_EN reads 0 and writes are ignored; pending registers still operate for polling.

Test Plan:
- Bench configuration: DebounceCycles=4, GpiWidth=8.
- Debounce latency: drive gp_i=8'h01 at cycle 0 -> VALUE reads 8'h01 from cycle 6 onward; RISE_PEND=8'h01.
- Glitch rejection: pulse gp_i[3]=1 for 3 cycles then 0 -> VALUE stays 8'h00; RISE_PEND and FALL_PEND stay 0.
- W1C and set-wins: with RISE_PEND=8'h03, write 8'h01 to RISE_PEND -> reads 8'h02. Issue a W1C of bit1 in the same cycle bit1 rises again -> reads 8'h02.
- Interrupt (GPI_IRQ_EN defined): IRQ_EN=8'h04, then bit2 falls -> irq_o=1 one cycle after FALL_PEND[2] sets. Write 8'h04 to FALL_PEND -> irq_o=0 next cycle. Without the macro -> irq_o stays 0 throughout.
- Bus timing: back-to-back reads of addr 0x0, 0x4, 0xC on consecutive cycles -> three consecutive rvalid cycles with matching data. A write with be=4'b0010 to IRQ_EN changes only bits [15:8].
- Async reset mid-count: assert rst_sys_ni low at counter=2 -> VALUE=0, pending=0, irq_o=0, rvalid=0 immediately. After release with a stable input, acceptance takes a full 6 cycles.
